// File: rtl/spi_cmd_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_cmd_rx
// Description : SPI command receiver (SPI slave, clk-domain oversampled).
//               spi_clk, spi_cs and spi_mosi are brought into the clk domain
//               through 2-flop synchronisers. On each frame the receiver
//               shifts in up to CMD_BIT_NUM command bits, MSB first, and
//               presents them right-aligned on data/data_num with a dready /
//               ack handshake. During the frame, a snapshot of pll_lock taken
//               at the cs falling edge is returned MSB first on spi_miso.
//
// Ports       : clk       in   system clock
//               rst       in   asynchronous reset, active low
//               spi_clk   in   SPI master clock (asynchronous to clk)
//               spi_cs    in   frame select, active low
//               spi_mosi  in   command data, MSB first
//               spi_miso  out  reply data, MSB first, 0 while cs is high
//               pll_lock  in   status word sampled at frame start
//               data      out  received frame, right-aligned, zero-extended
//               data_num  out  number of bits in the received frame
//               dready    out  data/data_num valid
//               ack       in   consumer acknowledge
//               overflow  out  sticky: a frame was longer than CMD_BIT_NUM
//               drop      out  sticky: a frame arrived while dready was high
//
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_rx #(
    parameter int CMD_BIT_NUM   = 51,
    parameter int REPLY_BIT_NUM = 6,
    parameter int SAMPLE_LEVEL  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spi_clk,
    input  logic                     spi_cs,
    input  logic                     spi_mosi,
    output logic                     spi_miso,
    input  logic [REPLY_BIT_NUM-1:0] pll_lock,
    output logic [CMD_BIT_NUM-1:0]   data,
    output logic [6:0]               data_num,
    output logic                     dready,
    input  logic                     ack,
    output logic                     overflow,
    output logic                     drop
);

    // Counter saturates one above the accepted maximum so that any longer
    // frame is still distinguishable as an overflow at cs rise.
    localparam logic [6:0] CNT_LIMIT = 7'(CMD_BIT_NUM);
    localparam logic [6:0] CNT_SAT   = 7'(CMD_BIT_NUM + 1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_SHIFT        = 2'd1,
        ST_PRESENT      = 2'd2,
        ST_WAIT_ACK_LOW = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers (<sig>_q) and their next-state values (<sig>_d)
    // ------------------------------------------------------------------
    logic                     cs_meta_q,   cs_meta_d;
    logic                     cs_sync_q,   cs_sync_d;
    logic                     cs_prev_q,   cs_prev_d;
    logic                     sclk_meta_q, sclk_meta_d;
    logic                     sclk_sync_q, sclk_sync_d;
    logic                     sclk_prev_q, sclk_prev_d;
    logic                     mosi_meta_q, mosi_meta_d;
    logic                     mosi_sync_q, mosi_sync_d;
    logic [1:0]               settle_q,    settle_d;
    logic                     armed_q,     armed_d;
    state_t                   state_q,     state_d;
    logic [CMD_BIT_NUM-1:0]   shreg_q,     shreg_d;
    logic [6:0]               cnt_q,       cnt_d;
    logic [REPLY_BIT_NUM-1:0] reply_q,     reply_d;
    logic                     miso_q,      miso_d;
    logic [CMD_BIT_NUM-1:0]   data_q,      data_d;
    logic [6:0]               data_num_q,  data_num_d;
    logic                     dready_q,    dready_d;
    logic                     overflow_q,  overflow_d;
    logic                     drop_q,      drop_d;

    // ------------------------------------------------------------------
    // Edge detection on the synchronised values
    // ------------------------------------------------------------------
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_sample_edge;
    logic                   w_drive_edge;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic [CMD_BIT_NUM-1:0] w_shreg_nx;
    logic [6:0]             w_cnt_nx;

    assign w_sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign w_sclk_fall = ~sclk_sync_q & sclk_prev_q;

    generate
        if (SAMPLE_LEVEL != 0) begin : g_sample_rise
            assign w_sample_edge = w_sclk_rise;
            assign w_drive_edge  = w_sclk_fall;
        end else begin : g_sample_fall
            assign w_sample_edge = w_sclk_fall;
            assign w_drive_edge  = w_sclk_rise;
        end
    endgenerate

    // A falling edge only counts once cs has been seen high through the
    // synchroniser after reset; the synchroniser's reset value of 1 would
    // otherwise fake a falling edge when cs is already low at release.
    assign w_cs_fall = armed_q & cs_prev_q & ~cs_sync_q;
    assign w_cs_rise = ~cs_prev_q & cs_sync_q;

    // Sample applied before the cs rise decision so that a sample edge and
    // a cs rise landing in the same clk still count the last bit.
    assign w_shreg_nx = w_sample_edge ? {shreg_q[CMD_BIT_NUM-2:0], mosi_sync_q} : shreg_q;
    assign w_cnt_nx   = (w_sample_edge && (cnt_q != CNT_SAT)) ? (cnt_q + 7'd1) : cnt_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        cs_meta_d   = spi_cs;
        cs_sync_d   = cs_meta_q;
        cs_prev_d   = cs_sync_q;
        sclk_meta_d = spi_clk;
        sclk_sync_d = sclk_meta_q;
        sclk_prev_d = sclk_sync_q;
        mosi_meta_d = spi_mosi;
        mosi_sync_d = mosi_meta_q;

        // cs_sync_q carries its reset value for the first two clks; it is
        // only trusted for arming once settle_q[1] is set.
        settle_d    = {settle_q[0], 1'b1};
        armed_d     = armed_q | (settle_q[1] & cs_sync_q);

        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        reply_d     = reply_q;
        miso_d      = miso_q;
        data_d      = data_q;
        data_num_d  = data_num_q;
        dready_d    = dready_q;
        overflow_d  = overflow_q;
        drop_d      = drop_q;

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (w_cs_fall) begin
                    shreg_d = '0;
                    cnt_d   = '0;
                    // MSB goes out straight away so it is valid before the
                    // master's first sample edge.
                    miso_d  = pll_lock[REPLY_BIT_NUM-1];
                    reply_d = pll_lock << 1;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (w_cs_rise) begin
                    miso_d = 1'b0;
                    if (w_cnt_nx == 7'd0) begin
                        state_d = ST_IDLE;
                    end else if (w_cnt_nx <= CNT_LIMIT) begin
                        data_d     = w_shreg_nx;
                        data_num_d = w_cnt_nx;
                        dready_d   = 1'b1;
                        state_d    = ST_PRESENT;
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    shreg_d = w_shreg_nx;
                    cnt_d   = w_cnt_nx;
                    if (w_drive_edge) begin
                        // Zeros shift in behind the reply, so miso reads 0
                        // once all status bits have gone out.
                        miso_d  = reply_q[REPLY_BIT_NUM-1];
                        reply_d = reply_q << 1;
                    end
                end
            end

            ST_PRESENT: begin
                miso_d = 1'b0;
                if (w_cs_fall) begin
                    drop_d = 1'b1;
                end
                if (ack) begin
                    dready_d = 1'b0;
                    state_d  = ST_WAIT_ACK_LOW;
                end
            end

            ST_WAIT_ACK_LOW: begin
                miso_d = 1'b0;
                if (w_cs_fall) begin
                    drop_d = 1'b1;
                end
                // A frame dropped here keeps cs low, so IDLE cannot see a
                // fresh falling edge until that frame has ended.
                if (!ack) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            settle_q    <= 2'b00;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            reply_q     <= '0;
            miso_q      <= 1'b0;
            data_q      <= '0;
            data_num_q  <= '0;
            dready_q    <= 1'b0;
            overflow_q  <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            cs_meta_q   <= cs_meta_d;
            cs_sync_q   <= cs_sync_d;
            cs_prev_q   <= cs_prev_d;
            sclk_meta_q <= sclk_meta_d;
            sclk_sync_q <= sclk_sync_d;
            sclk_prev_q <= sclk_prev_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_sync_q <= mosi_sync_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            reply_q     <= reply_d;
            miso_q      <= miso_d;
            data_q      <= data_d;
            data_num_q  <= data_num_d;
            dready_q    <= dready_d;
            overflow_q  <= overflow_d;
            drop_q      <= drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Gating with the raw cs keeps miso low the moment cs goes high, without
    // waiting for the synchroniser latency.
    assign spi_miso = miso_q & ~spi_cs;
    assign data     = data_q;
    assign data_num = data_num_q;
    assign dready   = dready_q;
    assign overflow = overflow_q;
    assign drop     = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_cmd_rx
// Description : Self-checking bench for spi_cmd_rx. Accepted frames are
//               pushed to a scoreboard when sent and popped on each dready
//               rising edge; scenario tasks check flags, latency and miso.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_rx;

    localparam int CMD_BIT_NUM   = 51;
    localparam int REPLY_BIT_NUM = 6;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     spi_clk;
    logic                     spi_cs;
    logic                     spi_mosi;
    logic                     spi_miso;
    logic [REPLY_BIT_NUM-1:0] pll_lock;
    logic [CMD_BIT_NUM-1:0]   data;
    logic [6:0]               data_num;
    logic                     dready;
    logic                     ack;
    logic                     overflow;
    logic                     drop;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [CMD_BIT_NUM-1:0] d;
        logic [6:0]             n;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic dready_prev = 1'b0;

    spi_cmd_rx #(
        .CMD_BIT_NUM  (CMD_BIT_NUM),
        .REPLY_BIT_NUM(REPLY_BIT_NUM),
        .SAMPLE_LEVEL (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .spi_clk (spi_clk),
        .spi_cs  (spi_cs),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .pll_lock(pll_lock),
        .data    (data),
        .data_num(data_num),
        .dready  (dready),
        .ack     (ack),
        .overflow(overflow),
        .drop    (drop)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every dready rising edge must match the oldest
    // expected frame.
    always @(negedge clk) begin
        if (dready === 1'b1 && dready_prev === 1'b0) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dready: got data=%h num=%0d, expected no frame", data, data_num);
            end else begin
                mon_e = sb_q.pop_front();
                if (data !== mon_e.d || data_num !== mon_e.n) begin
                    errors++;
                    $display("FAIL frame_data: got data=%h num=%0d, expected data=%h num=%0d",
                             data, data_num, mon_e.d, mon_e.n);
                end
            end
        end
        dready_prev <= dready;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // SPI master helpers (all SPI edges land 2ns after a clk rising edge)
    // ------------------------------------------------------------------
    task automatic spi_start();
        @(posedge clk);
        #2;
        spi_cs = 1'b0;
        #100;
    endtask

    task automatic spi_shift(input logic [63:0] v, input int n, input bit chk_miso,
                             input logic [REPLY_BIT_NUM-1:0] reply, input bit cs_on_last);
        for (int i = n - 1; i >= 0; i--) begin
            int   k;
            logic exp_b;
            k        = n - 1 - i;
            exp_b    = (k < REPLY_BIT_NUM) ? reply[REPLY_BIT_NUM-1-k] : 1'b0;
            spi_mosi = v[i];
            #50;
            if (chk_miso) begin
                checks++;
                if (spi_miso !== exp_b) begin
                    errors++;
                    $display("FAIL miso_bit%0d: got %b, expected %b", k, spi_miso, exp_b);
                end
            end
            spi_clk = 1'b1;
            if (cs_on_last && i == 0) spi_cs = 1'b1;
            #50;
            spi_clk = 1'b0;
        end
    endtask

    task automatic spi_stop();
        #100;
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        #200;
    endtask

    task automatic wait_dready();
        int n;
        n = 0;
        while (dready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dready !== 1'b1) begin
            errors++;
            $display("FAIL dready_timeout: got dready=%b, expected 1 within 200 clks", dready);
        end
    endtask

    task automatic do_ack();
        @(posedge clk);
        #1 ack = 1'b1;
        @(negedge clk);
        checks++;
        if (dready !== 1'b1) begin
            errors++;
            $display("FAIL ack_hold: got dready=%b, expected 1 before ack is sampled", dready);
        end
        @(negedge clk);
        checks++;
        if (dready !== 1'b0) begin
            errors++;
            $display("FAIL ack_release: got dready=%b, expected 0 one clk after ack", dready);
        end
        @(posedge clk);
        #1 ack = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (data !== '0 || data_num !== 7'd0 || dready !== 1'b0 || spi_miso !== 1'b0 ||
            overflow !== 1'b0 || drop !== 1'b0) begin
            errors++;
            $display("FAIL %s: got data=%h num=%0d dready=%b miso=%b ovf=%b drop=%b, expected all 0",
                     tag, data, data_num, dready, spi_miso, overflow, drop);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst      = 1'b0;
        spi_cs   = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        ack      = 1'b0;
        pll_lock = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    task automatic test_full_frame();
        logic [63:0] v;
        v        = 64'h7_FFFF_0000_1235;
        pll_lock = 6'b010011;
        sb_q.push_back('{d: CMD_BIT_NUM'(v), n: 7'd51});
        spi_start();
        spi_shift(v, 51, 1'b1, 6'b010011, 1'b0);
        #100;
        spi_cs   = 1'b0;
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dready !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got dready=%b, expected 0 at 3rd negedge after cs rise", dready);
        end
        @(negedge clk);
        checks++;
        if (dready !== 1'b1) begin
            errors++;
            $display("FAIL latency: got dready=%b, expected 1 at 4th negedge after cs rise", dready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dready !== 1'b1 || data !== 51'h7FFFF00001235 || data_num !== 7'd51) begin
                errors++;
                $display("FAIL hold_stable%0d: got dready=%b data=%h num=%0d, expected 1/7ffff00001235/51",
                         i, dready, data, data_num);
            end
        end
        do_ack();
    endtask

    task automatic test_reply();
        logic [63:0] v;
        v        = 64'h1DEA_DBEE_F5A7;
        pll_lock = 6'b101100;
        sb_q.push_back('{d: CMD_BIT_NUM'(v), n: 7'd45});
        spi_start();
        spi_shift(v, 45, 1'b1, 6'b101100, 1'b0);
        spi_stop();
        checks++;
        if (spi_miso !== 1'b0) begin
            errors++;
            $display("FAIL miso_cs_high: got %b, expected 0", spi_miso);
        end
        wait_dready();
        do_ack();
    endtask

    task automatic test_empty_frame();
        spi_start();
        spi_stop();
        repeat (20) @(negedge clk);
        checks++;
        if (dready !== 1'b0 || overflow !== 1'b0 || drop !== 1'b0) begin
            errors++;
            $display("FAIL empty_frame: got dready=%b ovf=%b drop=%b, expected 0/0/0", dready, overflow, drop);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] v;
        spi_start();
        spi_shift(64'hF_0F0F_0F0F_0F0F, 52, 1'b0, '0, 1'b0);
        spi_stop();
        repeat (10) @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || dready !== 1'b0) begin
            errors++;
            $display("FAIL overflow_52: got ovf=%b dready=%b, expected 1/0", overflow, dready);
        end
        v = 64'h5_5555_AAAA_F0F1;
        sb_q.push_back('{d: CMD_BIT_NUM'(v), n: 7'd51});
        spi_start();
        spi_shift(v, 51, 1'b0, '0, 1'b0);
        spi_stop();
        wait_dready();
        do_ack();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got %b, expected 1", overflow);
        end
    endtask

    task automatic test_drop();
        sb_q.push_back('{d: CMD_BIT_NUM'(64'h1234), n: 7'd16});
        spi_start();
        spi_shift(64'h1234, 16, 1'b0, '0, 1'b0);
        spi_stop();
        wait_dready();
        spi_start();
        spi_shift(64'hFF, 8, 1'b0, '0, 1'b0);
        spi_stop();
        checks++;
        if (drop !== 1'b1 || dready !== 1'b1 || data !== 51'h1234 || data_num !== 7'd16) begin
            errors++;
            $display("FAIL drop_hold: got drop=%b dready=%b data=%h num=%0d, expected 1/1/1234/16",
                     drop, dready, data, data_num);
        end
        do_ack();
        sb_q.push_back('{d: CMD_BIT_NUM'(64'h3C0DE), n: 7'd18});
        spi_start();
        spi_shift(64'h3C0DE, 18, 1'b0, '0, 1'b0);
        spi_stop();
        wait_dready();
        do_ack();
    endtask

    task automatic test_reset_midframe();
        logic [63:0] v;
        v = 64'h6_1234_5678_9ABC;
        spi_start();
        spi_shift(v >> 31, 20, 1'b0, '0, 1'b0);
        #20;
        rst = 1'b0;
        #30;
        check_reset_outputs("midframe_reset");
        rst = 1'b1;
        #20;
        spi_shift(v, 31, 1'b0, '0, 1'b0);
        spi_stop();
        repeat (20) @(negedge clk);
        checks++;
        if (dready !== 1'b0) begin
            errors++;
            $display("FAIL aborted_frame: got dready=%b, expected 0", dready);
        end
        sb_q.push_back('{d: CMD_BIT_NUM'(v), n: 7'd51});
        spi_start();
        spi_shift(v, 51, 1'b0, '0, 1'b0);
        spi_stop();
        wait_dready();
        do_ack();
    endtask

    task automatic test_same_edge();
        // ack while idle must not disturb the next frame
        @(posedge clk);
        #1 ack = 1'b1;
        repeat (5) @(posedge clk);
        #1 ack = 1'b0;
        sb_q.push_back('{d: CMD_BIT_NUM'(64'h2A5), n: 7'd10});
        spi_start();
        spi_shift(64'h2A5, 10, 1'b0, '0, 1'b1);
        #200;
        wait_dready();
        repeat (3) @(negedge clk);
        checks++;
        if (dready !== 1'b1) begin
            errors++;
            $display("FAIL ack_idle_effect: got dready=%b, expected 1 until ack", dready);
        end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_reply();
        test_empty_frame();
        test_overflow();
        test_drop();
        test_reset_midframe();
        test_same_edge();
        repeat (10) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending frames, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_cmd_rx.md
SPI_CMD_RX -- requirements
Module: spi_cmd_rx

Interface
REQ-001 SHALL have parameter CMD_BIT_NUM, default 51: maximum accepted frame length in bits.
REQ-002 SHALL have parameter REPLY_BIT_NUM, default 6: number of status bits returned on spi_miso.
REQ-003 SHALL have parameter SAMPLE_LEVEL, default 1: 1 = sample mosi on spi_clk rising edge and drive miso on falling edge; 0 = the reverse.
REQ-004 Ports, clock and reset first:
- clk  in  1  system clock; one clock only.
- rst  in  1  reset, asynchronous, active-low.
- spi_clk  in  1  master SPI clock, asynchronous to clk.
- spi_cs  in  1  frame select, active low.
- spi_mosi  in  1  command data, MSB first.
- spi_miso  out  1  reply data, MSB first.
- pll_lock  in  REPLY_BIT_NUM  status snapshot source.
- data  out  CMD_BIT_NUM  received frame, right-aligned, zero-extended.
- data_num  out  7  number of bits received in the frame.
- dready  out  1  data/data_num valid.
- ack  in  1  consumer acknowledge.
- overflow  out  1  sticky: a frame exceeded CMD_BIT_NUM bits.
- drop  out  1  sticky: a frame arrived while dready was high.

Function
REQ-005 SHALL pass spi_clk, spi_cs and spi_mosi through 2-flop synchronisers in the clk domain; all edge detection SHALL use the synchronised values.
REQ-006 State machine states: IDLE, SHIFT, PRESENT, WAIT_ACK_LOW.
REQ-007 IDLE: on a synchronised cs falling edge, SHALL clear the shift register and bit counter, snapshot pll_lock into the reply register, and go to SHIFT.
REQ-008 SHIFT: on each active sample edge, SHALL shift mosi into the LSB of the shift register and increment the counter. The counter SHALL saturate at CMD_BIT_NUM+1.
REQ-009 SHIFT: on the drive edge, SHALL shift the reply register out MSB first. After REPLY_BIT_NUM bits, spi_miso SHALL be 0.
REQ-010 SHIFT, on cs rising edge:
- count 0: return to IDLE with no output.
- count 1..CMD_BIT_NUM: load data and data_num, assert dready, go to PRESENT.
- count > CMD_BIT_NUM: set overflow, discard the frame, return to IDLE.
REQ-011 Latency: dready SHALL assert exactly 1 clk after the synchronised cs rising edge is detected.
REQ-012 PRESENT: data and data_num SHALL hold stable while dready is high. When ack is seen high, dready SHALL drop on the next clk, then the block SHALL go to WAIT_ACK_LOW.
REQ-013 WAIT_ACK_LOW: SHALL go to IDLE when ack is low.
REQ-014 SHALL ignore cs falling edges while in PRESENT or WAIT_ACK_LOW, set drop, and discard that frame entirely, including any spi_clk edges up to its cs rising edge.
REQ-015 A sample edge and a cs rising edge in the same clk: the sample SHALL be counted first.
REQ-016 ack high while in IDLE or SHIFT SHALL have no effect.
REQ-017 spi_miso SHALL be 0 whenever cs is high.
REQ-018 overflow and drop SHALL clear only on reset.

Reset
REQ-019 While rst is low, all of the following SHALL hold:
- data = 0, data_num = 0, dready = 0, spi_miso = 0, overflow = 0, drop = 0.
- state = IDLE.
- synchronisers = 1 for cs, 0 for clk and mosi.
REQ-020 Reset asserted mid-frame SHALL abort the frame. After release, the block SHALL wait for a fresh cs falling edge. A cs already low at release SHALL NOT start a frame.

Verification
REQ-021 51-bit frame 0x7_FFFF_0000_1235, ack returned 3 clk after dready -> data = 0x7FFFF00001235, data_num = 51, dready high until 1 clk after ack.
REQ-022 45-bit frame, pll_lock = 6'b101100 at cs fall -> data_num = 45, data[44:0] = frame, miso bits = 1,0,1,1,0,0 then 0.
REQ-023 52-bit frame -> overflow = 1, dready stays 0, next 51-bit frame is accepted normally.
REQ-024 Second frame sent while dready is held (ack low) -> drop = 1, data unchanged. After ack, the third frame is received correctly.
REQ-025 cs low/high with no spi_clk edges -> no dready, no flags set.
REQ-026 rst pulsed low after 20 bits of a frame -> outputs at reset values. The remainder of that frame produces no dready. The next full frame is accepted.
